// File: rtl/mix_column_seq_pkg.sv
// Shared AES types for the MixColumns sequencer: FSM states, 128-bit state type,
// and the FIPS-197 byte-index helper.
package mix_column_seq_pkg;

  typedef enum logic [1:0] {
    IDLE,
    FEED,
    FLUSH,
    OUT
  } mc_state_e;

  typedef logic [127:0] aes_state_t;

  // Byte n occupies [127-8n -: 8]; shifting left brings it to the top byte.
  function automatic logic [7:0] state_byte(input aes_state_t s, input logic [3:0] n);
    aes_state_t t;
    t = s << {n, 3'b000};
    return t[127:120];
  endfunction

endpackage

// File: rtl/mix_column_seq_fsm.sv
// Control for the byte-serial MixColumns sequencer: state register, byte
// counter k, handshake flags, datapath load strobe and column-capture strobes.
module mix_column_seq_fsm
  import mix_column_seq_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  input  logic       skip,
  input  logic       out_ready,
  output logic [3:0] k,
  output logic       in_ready,
  output logic       out_valid,
  output logic       busy,
  output logic       accept,
  output logic       mc_en,
  output logic       feed,
  output logic       capture,
  output logic [1:0] capture_col
);

  mc_state_e state;
  mc_state_e state_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      k     <= '0;
    end else begin
      state <= state_nxt;
      if (state == FEED) begin
        k <= k + 4'd1;
      end else begin
        k <= '0;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (in_valid) state_nxt = skip ? OUT : FEED;
      FEED:    if (k == 4'd15) state_nxt = FLUSH;
      FLUSH:   state_nxt = OUT;
      OUT:     if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Every output falls back to its idle value while rst is high.
  always_comb begin
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    busy        = 1'b0;
    accept      = 1'b0;
    mc_en       = 1'b1;
    feed        = 1'b0;
    capture     = 1'b0;
    capture_col = k[3:2] - 2'd1;
    if (!rst) begin
      busy = (state != IDLE);
      unique case (state)
        IDLE: begin
          in_ready = 1'b1;
          accept   = in_valid;
        end
        FEED: begin
          feed    = 1'b1;
          mc_en   = (k[1:0] == 2'd0);
          capture = (k[1:0] == 2'd0) && (k != 4'd0);
        end
        FLUSH: begin
          capture     = 1'b1;
          capture_col = 2'd3;
        end
        OUT: begin
          out_valid = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/mix_column_seq.sv
// Byte-serial MixColumns sequencer top: holds the input block, byte mux and
// result register. Optional final-round bypass via MIX_COLUMN_SEQ_BYPASS_EN.
module mix_column_seq
  import mix_column_seq_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  input  logic         in_encrypt,
`ifdef MIX_COLUMN_SEQ_BYPASS_EN
  input  logic         in_skip,
`endif
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
  output logic         busy,
  output logic         mc_en,
  output logic         mc_encrypt,
  output logic [7:0]   mc_d_in,
  input  logic [7:0]   mc_d_out0,
  input  logic [7:0]   mc_d_out1,
  input  logic [7:0]   mc_d_out2,
  input  logic [7:0]   mc_d_out3
);

  logic       skip;
  logic [3:0] k;
  logic       accept;
  logic       feed;
  logic       capture;
  logic [1:0] capture_col;
  aes_state_t blk_q;
  aes_state_t out_q;
  logic       enc_q;
  logic [31:0] col_res;

`ifdef MIX_COLUMN_SEQ_BYPASS_EN
  assign skip = in_skip;
`else
  assign skip = 1'b0;
`endif

  mix_column_seq_fsm u_fsm (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .skip        (skip),
    .out_ready   (out_ready),
    .k           (k),
    .in_ready    (in_ready),
    .out_valid   (out_valid),
    .busy        (busy),
    .accept      (accept),
    .mc_en       (mc_en),
    .feed        (feed),
    .capture     (capture),
    .capture_col (capture_col)
  );

  assign col_res = {mc_d_out0, mc_d_out1, mc_d_out2, mc_d_out3};

  // A skipped block is written straight into the result register at accept.
  always_ff @(posedge clk) begin
    if (rst) begin
      blk_q <= '0;
      enc_q <= 1'b1;
      out_q <= '0;
    end else begin
      if (accept) begin
        blk_q <= in_data;
        enc_q <= in_encrypt;
        if (skip) begin
          out_q <= in_data;
        end
      end
      if (capture) begin
        unique case (capture_col)
          2'd0: out_q[127:96] <= col_res;
          2'd1: out_q[95:64]  <= col_res;
          2'd2: out_q[63:32]  <= col_res;
          2'd3: out_q[31:0]   <= col_res;
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    mc_d_in = '0;
    if (feed) begin
      mc_d_in = state_byte(blk_q, k);
    end
  end

  assign out_data   = out_q;
  assign mc_encrypt = enc_q;

endmodule

// File: tb/tb_mix_column_seq.sv
// Directed bench for mix_column_seq with a behavioural byte-serial (Inv)MixColumns
// datapath model on the mc_* ports. Bypass test enabled by MIX_COLUMN_SEQ_BYPASS_EN.
`timescale 1ns/1ps
module tb_mix_column_seq;
  import mix_column_seq_pkg::*;

  localparam aes_state_t VEC_A = 128'hdb135345_f20a225c_01010101_d4d4d4d5;
  localparam aes_state_t VEC_B = 128'h8e4da1bc_9fdc589d_01010101_d5d5d7d6;
  localparam aes_state_t VEC_C6 = {16{8'hc6}};

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  aes_state_t   in_data = '0;
  logic         in_encrypt = 1'b1;
`ifdef MIX_COLUMN_SEQ_BYPASS_EN
  logic         in_skip = 1'b0;
`endif
  logic         out_valid;
  logic         out_ready = 1'b0;
  aes_state_t   out_data;
  logic         busy;
  logic         mc_en;
  logic         mc_encrypt;
  logic [7:0]   mc_d_in;
  logic [7:0]   acc [4];
  logic [1:0]   idx;

  int n_tests = 0;
  int n_fail = 0;
  int edges = 0;
  int e0 = 0;
  logic [17:0] en_hist;
  logic [7:0]  din_or;

  always #5 clk = ~clk;
  always @(posedge clk) edges <= edges + 1;

  mix_column_seq dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_encrypt (in_encrypt),
`ifdef MIX_COLUMN_SEQ_BYPASS_EN
    .in_skip    (in_skip),
`endif
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .busy       (busy),
    .mc_en      (mc_en),
    .mc_encrypt (mc_encrypt),
    .mc_d_in    (mc_d_in),
    .mc_d_out0  (acc[0]),
    .mc_d_out1  (acc[1]),
    .mc_d_out2  (acc[2]),
    .mc_d_out3  (acc[3])
  );

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // Circulant matrix entry M[r][i] = m[(i-r) mod 4].
  function automatic logic [7:0] coef(input logic enc, input logic [1:0] r, input logic [1:0] i);
    logic [1:0] d;
    d = i - r;
    case (d)
      2'd0:    return enc ? 8'h02 : 8'h0e;
      2'd1:    return enc ? 8'h03 : 8'h0b;
      2'd2:    return enc ? 8'h01 : 8'h0d;
      default: return enc ? 8'h01 : 8'h09;
    endcase
  endfunction

  always @(posedge clk) begin
    for (int r = 0; r < 4; r++) begin
      if (mc_en) acc[r] <= gmul(coef(mc_encrypt, 2'(r), 2'd0), mc_d_in);
      else       acc[r] <= acc[r] ^ gmul(coef(mc_encrypt, 2'(r), idx), mc_d_in);
    end
    idx <= mc_en ? 2'd1 : idx + 2'd1;
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge of cycle E0+1.
  task automatic start_block(input aes_state_t d, input logic enc);
    logic ok;
    ok = 1'b0;
    in_valid = 1'b1;
    in_data = d;
    in_encrypt = enc;
    en_hist = '0;
    din_or = '0;
    for (int n = 0; n < 50; n++) begin
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check("accept", 128'(ok), 128'd1);
    e0 = edges + 1;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_out(output int lat, output logic ok);
    int rel;
    ok = 1'b0;
    lat = 0;
    for (int n = 0; n < 60; n++) begin
      rel = edges + 1 - e0;
      if (rel >= 1 && rel <= 18) en_hist[rel-1] = mc_en;
      din_or = din_or | mc_d_in;
      if (out_valid) begin
        ok = 1'b1;
        lat = rel;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic take_out();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  int   lat;
  logic ok;
  logic flag;
  aes_state_t snap;

  initial begin
    repeat (3) @(negedge clk);
    check("in_ready_in_rst", 128'(in_ready), 128'd0);
    rst = 1'b0;
    @(negedge clk);
    check("rst_in_ready", 128'(in_ready), 128'd1);
    check("rst_out_valid", 128'(out_valid), 128'd0);
    check("rst_busy", 128'(busy), 128'd0);
    check("rst_out_data", out_data, 128'd0);
    check("rst_mc_en", 128'(mc_en), 128'd1);
    check("rst_mc_encrypt", 128'(mc_encrypt), 128'd1);
    check("rst_mc_d_in", 128'(mc_d_in), 128'd0);

    // Encrypt with latency and mc_en pattern.
    start_block(VEC_A, 1'b1);
    check("enc_busy", 128'(busy), 128'd1);
    wait_out(lat, ok);
    check("enc_valid", 128'(ok), 128'd1);
    check("enc_latency", 128'(lat), 128'd18);
    check("enc_data", out_data, VEC_B);
    check("mc_en_pattern", 128'(en_hist), 128'h31111);
    check("out_mc_d_in", 128'(mc_d_in), 128'd0);
    take_out();
    check("hs_out_valid", 128'(out_valid), 128'd0);
    check("hs_in_ready", 128'(in_ready), 128'd1);

    // Decrypt.
    start_block(VEC_B, 1'b0);
    check("dec_mc_encrypt", 128'(mc_encrypt), 128'd0);
    wait_out(lat, ok);
    check("dec_valid", 128'(ok), 128'd1);
    check("dec_data", out_data, VEC_A);
    take_out();
    check("idle_mc_encrypt", 128'(mc_encrypt), 128'd0);

    // Stall 5 cycles with next block waiting.
    start_block(VEC_A, 1'b1);
    wait_out(lat, ok);
    check("stall_valid", 128'(ok), 128'd1);
    snap = out_data;
    in_valid = 1'b1;
    in_data = VEC_B;
    in_encrypt = 1'b0;
    flag = 1'b1;
    for (int n = 0; n < 5; n++) begin
      if (out_data !== snap || in_ready !== 1'b0 || out_valid !== 1'b1) flag = 1'b0;
      @(negedge clk);
    end
    check("stall_stable", 128'(flag), 128'd1);
    check("stall_data", out_data, VEC_B);
    take_out();
    check("b2b_in_ready", 128'(in_ready), 128'd1);
    e0 = edges + 1;
    @(negedge clk);
    in_valid = 1'b0;
    check("b2b_busy", 128'(busy), 128'd1);
    wait_out(lat, ok);
    check("b2b_valid", 128'(ok), 128'd1);
    check("b2b_latency", 128'(lat), 128'd18);
    check("b2b_data", out_data, VEC_A);
    take_out();

    // Reset in cycle E0+7.
    start_block(VEC_A, 1'b1);
    repeat (6) @(negedge clk);
    rst = 1'b1;
    #1;
    check("mid_rst_in_ready", 128'(in_ready), 128'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("post_rst_in_ready", 128'(in_ready), 128'd1);
    check("post_rst_busy", 128'(busy), 128'd0);
    flag = 1'b0;
    for (int n = 0; n < 25; n++) begin
      if (out_valid) flag = 1'b1;
      @(negedge clk);
    end
    check("post_rst_no_valid", 128'(flag), 128'd0);
    start_block(VEC_C6, 1'b1);
    wait_out(lat, ok);
    check("c6_valid", 128'(ok), 128'd1);
    check("c6_data", out_data, VEC_C6);
    take_out();

`ifdef MIX_COLUMN_SEQ_BYPASS_EN
    in_skip = 1'b1;
    start_block(128'h00112233_44556677_8899aabb_ccddeeff, 1'b1);
    in_skip = 1'b0;
    wait_out(lat, ok);
    check("skip_valid", 128'(ok), 128'd1);
    check("skip_latency", 128'(lat), 128'd1);
    check("skip_data", out_data, 128'h00112233_44556677_8899aabb_ccddeeff);
    check("skip_mc_d_in", 128'(din_or), 128'd0);
    check("skip_mc_en", 128'(en_hist[0]), 128'd1);
    take_out();
    check("skip_in_ready", 128'(in_ready), 128'd1);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
